// File: rtl/spi_slave_fifo.sv
// SPI slave with TX and RX word FIFOs on the system clock side.
// SCK, CS_N and MOSI are oversampled on clk. Edges come from synchronizer
// stages 2 and 3. All serial activity is gated by the synchronized chip select.

// Small synchronous FIFO with show-ahead head. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module spi_slave_fifo_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_q];

  // Storage write; contents need no reset since the count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

module spi_slave_fifo #(
  parameter int WORD_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter int LSB_FIRST  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sck,
  input  logic                 cs_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 miso_oe,
  input  logic [WORD_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [WORD_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overflow,
  output logic                 tx_underrun,
  output logic                 busy
);
  localparam int W  = WORD_BITS;
  localparam int CW = $clog2(WORD_BITS);

  // Synchronizers: index 0 is the first flop
  logic [2:0] sck_q, cs_q;
  logic [1:0] mosi_q;
  // Set once CS has been seen inactive after reset, so a CS held low through
  // reset cannot start a word.
  logic       arm_q;

  logic cs_act, cs_fall;
  logic sck_rise, sck_fall, lead_e, trail_e, samp_e, shift_e, load_e;

  logic [CW-1:0] bit_cnt_q;
  logic [W-1:0]  rx_sh_q, rx_next_d;
  logic          done_q;
  logic          word_end;

  logic [W-1:0]  tx_sh_q, tx_head;
  logic          tx_full, tx_empty, tx_push, tx_pop;
  logic [W-1:0]  rx_head;
  logic          rx_full, rx_empty, rx_pop;
  logic          ovf_q, und_q;

  // Input synchronizers and the post-reset arm flag
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q  <= '0;
      cs_q   <= '0;
      mosi_q <= '0;
      arm_q  <= 1'b0;
    end else begin
      sck_q  <= {sck_q[1:0], sck};
      cs_q   <= {cs_q[1:0], cs_n};
      mosi_q <= {mosi_q[0], mosi};
      if (cs_q[1]) arm_q <= 1'b1;
    end
  end

  assign cs_act   = arm_q & ~cs_q[1];
  assign cs_fall  = cs_act & cs_q[2];
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign lead_e   = (CPOL != 0) ? sck_fall : sck_rise;
  assign trail_e  = (CPOL != 0) ? sck_rise : sck_fall;
  assign samp_e   = cs_act & ((CPHA != 0) ? trail_e : lead_e);
  assign shift_e  = cs_act & ((CPHA != 0) ? lead_e : trail_e);

  // CPHA=0 preloads at CS assertion and after each word; CPHA=1 loads on the
  // first shift edge of every word.
  assign load_e = (CPHA != 0) ? (shift_e & (bit_cnt_q == '0))
                              : (cs_fall | (shift_e & done_q));

  assign rx_next_d = (LSB_FIRST != 0) ? {mosi_q[1], rx_sh_q[W-1:1]}
                                      : {rx_sh_q[W-2:0], mosi_q[1]};
  assign word_end  = samp_e & (bit_cnt_q == CW'(W-1));

  // Receive shifter and bit counter; partial words die with CS
  always_ff @(posedge clk) begin
    if (rst || !cs_act) begin
      bit_cnt_q <= '0;
      rx_sh_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      if (samp_e) begin
        rx_sh_q   <= rx_next_d;
        bit_cnt_q <= word_end ? '0 : bit_cnt_q + CW'(1);
      end
      if (word_end)     done_q <= 1'b1;
      else if (shift_e) done_q <= 1'b0;
    end
  end

  assign tx_push = tx_valid & tx_ready;
  assign tx_pop  = load_e & ~tx_empty;

  // Transmit shifter; a loaded word is dropped, not returned, when CS ends
  always_ff @(posedge clk) begin
    if (rst || !cs_act) begin
      tx_sh_q <= '0;
    end else if (load_e) begin
      tx_sh_q <= tx_empty ? '0 : tx_head;
    end else if (shift_e) begin
      tx_sh_q <= (LSB_FIRST != 0) ? (tx_sh_q >> 1) : (tx_sh_q << 1);
    end
  end

  assign rx_pop = rx_ready & ~rx_empty & ~rst;

  // Single-cycle event pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      und_q <= 1'b0;
    end else begin
      ovf_q <= word_end & rx_full & ~rx_pop;
      und_q <= load_e & tx_empty;
    end
  end

  spi_slave_fifo_buf #(.W(W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .din_i   (tx_data),
    .pop_i   (tx_pop),
    .dout_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  spi_slave_fifo_buf #(.W(W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (word_end),
    .din_i   (rx_next_d),
    .pop_i   (rx_pop),
    .dout_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  // Outputs are forced to idle values for the whole reset window
  assign busy        = ~rst & cs_act;
  assign miso_oe     = busy;
  assign miso        = busy & ((LSB_FIRST != 0) ? tx_sh_q[0] : tx_sh_q[W-1]);
  assign tx_ready    = ~rst & ~tx_full;
  assign rx_valid    = ~rst & ~rx_empty;
  assign rx_data     = rst ? '0 : rx_head;
  assign rx_overflow = ~rst & ovf_q;
  assign tx_underrun = ~rst & und_q;
endmodule
